// File: rtl/perceptron_trainer.sv
// perceptron_trainer: trains the two weights of an external perceptron against a 4-entry truth table
module perceptron_trainer #(
  parameter int WINDOW     = 4,
  parameter int MAX_EPOCHS = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [3:0] target_tt,
  input  logic [2:0] init_w1,
  input  logic [2:0] init_w2,
  input  logic       v_out,
  output logic       v_in1,
  output logic       v_in2,
  output logic [2:0] w1_out,
  output logic [2:0] w2_out,
  output logic       neuron_rst_n,
  output logic       busy,
  output logic       done,
  output logic       converged,
  output logic [3:0] epoch_cnt,
  output logic [2:0] err_cnt
);
  typedef enum logic [2:0] {IDLE, CLEAR, APPLY, UPDATE, EPOCH_END, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] p_q, p_d;
  logic [3:0] cnt_q, cnt_d, epoch_q, epoch_d;
  logic [2:0] w1_q, w1_d, w2_q, w2_d, err_q, err_d, tally_q, tally_d;
  logic spike_q, spike_d, conv_q, conv_d;
  logic vin1_q, vin1_d, vin2_q, vin2_d, nrst_q, nrst_d, busy_q, busy_d, done_q, done_d;
  logic tgt, miss, fire;
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    epoch_d = epoch_q;
    w1_d    = w1_q;
    w2_d    = w2_q;
    err_d   = err_q;
    tally_d = tally_q;
    spike_d = spike_q;
    conv_d  = conv_q;
    tgt     = target_tt[p_q];
    miss    = tgt && !spike_q;
    fire    = !tgt && spike_q;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d = CLEAR;
        p_d     = 2'd0;
        w1_d    = init_w1;
        w2_d    = init_w2;
        epoch_d = 4'd0;
        tally_d = 3'd0;
        conv_d  = 1'b0;
      end
      CLEAR: begin
        state_d = APPLY;
        cnt_d   = 4'd0;
        spike_d = 1'b0;
      end
      APPLY: begin
        spike_d = spike_q | v_out;
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(WINDOW - 1)) ? UPDATE : APPLY;
      end
      UPDATE: begin
        tally_d = (miss || fire) ? tally_q + 3'd1 : tally_q;
        w1_d    = (miss && p_q[0] && w1_q != 3'd7) ? w1_q + 3'd1 :
                  (fire && p_q[0] && w1_q != 3'd0) ? w1_q - 3'd1 : w1_q;
        w2_d    = (miss && p_q[1] && w2_q != 3'd7) ? w2_q + 3'd1 :
                  (fire && p_q[1] && w2_q != 3'd0) ? w2_q - 3'd1 : w2_q;
        p_d     = p_q + 2'd1;
        state_d = (p_q == 2'd3) ? EPOCH_END : CLEAR;
      end
      EPOCH_END: begin
        epoch_d = epoch_q + 4'd1;
        err_d   = tally_q;
        tally_d = 3'd0;
        p_d     = 2'd0;
        conv_d  = (tally_q == 3'd0);
        state_d = (tally_q == 3'd0 || epoch_q + 4'd1 == 4'(MAX_EPOCHS)) ? DONE : CLEAR;
      end
      default: state_d = IDLE;
    endcase
    vin1_d = (state_d == APPLY) && p_d[0];
    vin2_d = (state_d == APPLY) && p_d[1];
    nrst_d = (state_d != CLEAR);
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      p_q     <= 2'd0;
      cnt_q   <= 4'd0;
      epoch_q <= 4'd0;
      w1_q    <= 3'd0;
      w2_q    <= 3'd0;
      err_q   <= 3'd0;
      tally_q <= 3'd0;
      spike_q <= 1'b0;
      conv_q  <= 1'b0;
      vin1_q  <= 1'b0;
      vin2_q  <= 1'b0;
      nrst_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      epoch_q <= epoch_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      err_q   <= err_d;
      tally_q <= tally_d;
      spike_q <= spike_d;
      conv_q  <= conv_d;
      vin1_q  <= vin1_d;
      vin2_q  <= vin2_d;
      nrst_q  <= nrst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign v_in1        = vin1_q;
  assign v_in2        = vin2_q;
  assign w1_out       = w1_q;
  assign w2_out       = w2_q;
  assign neuron_rst_n = nrst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign converged    = conv_q;
  assign epoch_cnt    = epoch_q;
  assign err_cnt      = err_q;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb_perceptron_trainer: directed checks of perceptron_trainer with a behavioural neuron stub
module tb_perceptron_trainer;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, v_out;
  logic [3:0] target_tt = 4'd0;
  logic [2:0] init_w1 = 3'd0, init_w2 = 3'd0;
  logic v_in1, v_in2, neuron_rst_n, busy, done, converged;
  logic [2:0] w1_out, w2_out, err_cnt;
  logic [3:0] epoch_cnt;
  int total = 0, bad = 0;
  int mode = 0;
  int k3 = 0;
  always #5 clk = ~clk;
  perceptron_trainer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .target_tt(target_tt),
    .init_w1(init_w1), .init_w2(init_w2), .v_out(v_out),
    .v_in1(v_in1), .v_in2(v_in2), .w1_out(w1_out), .w2_out(w2_out),
    .neuron_rst_n(neuron_rst_n), .busy(busy), .done(done), .converged(converged),
    .epoch_cnt(epoch_cnt), .err_cnt(err_cnt)
  );
  // neuron stub: mode 0 never spikes, 1 always spikes, 2 spikes only in the last window cycle of pattern 3
  always @(posedge clk) k3 <= (v_in1 && v_in2) ? k3 + 1 : 0;
  assign v_out = (mode == 1) ? 1'b1 : (mode == 2) ? (v_in1 && v_in2 && k3 == 3) : 1'b0;
  typedef struct {
    int mode; logic [3:0] tgt; int iw1, iw2;
    int cyc, conv, ep, err, w1, w2;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask
  task automatic launch(input vec_t v);
    @(negedge clk);
    mode = v.mode; target_tt = v.tgt; init_w1 = 3'(v.iw1); init_w2 = 3'(v.iw2); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask
  task automatic run(input vec_t v, input bit extra, input string tag);
    int n;
    launch(v);
    n = 0;
    while (n < 1000) begin
      @(posedge clk);
      n++;
      #1;
      if (done) break;
      start = extra && (n % 37 == 5);
    end
    start = 1'b0;
    chk({tag, "_cycles"}, n, v.cyc);
    chk({tag, "_conv"}, int'(converged), v.conv);
    chk({tag, "_epoch"}, int'(epoch_cnt), v.ep);
    chk({tag, "_err"}, int'(err_cnt), v.err);
    chk({tag, "_w1"}, int'(w1_out), v.w1);
    chk({tag, "_w2"}, int'(w2_out), v.w2);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_w1"}, int'(w1_out), 0);
    chk({tag, "_w2"}, int'(w2_out), 0);
    chk({tag, "_vin"}, int'({v_in1, v_in2}), 0);
    chk({tag, "_nrst"}, int'(neuron_rst_n), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_conv"}, int'(converged), 0);
    chk({tag, "_epoch"}, int'(epoch_cnt), 0);
    chk({tag, "_err"}, int'(err_cnt), 0);
  endtask
  initial begin
    int w_exp[3];
    bit hit;
    vecs[0] = '{0, 4'b0000, 3, 5, 25, 1, 1, 0, 3, 5};
    vecs[1] = '{0, 4'b1000, 0, 0, 375, 0, 15, 1, 7, 7};
    vecs[2] = '{1, 4'b0000, 5, 5, 375, 0, 15, 4, 0, 0};
    vecs[3] = '{2, 4'b1000, 2, 6, 25, 1, 1, 0, 2, 6};
    vecs[4] = '{0, 4'b0001, 4, 4, 375, 0, 15, 1, 4, 4};
    vecs[5] = '{1, 4'b1111, 1, 2, 25, 1, 1, 0, 1, 2};
    vecs[6] = '{0, 4'b0010, 0, 3, 375, 0, 15, 1, 7, 3};
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 7; i++) run(vecs[i], 1'b0, $sformatf("vec%0d", i));
    // weight trajectory while decrementing: 5/5 -> 3/3 -> 1/1 -> 0/0
    w_exp = '{3, 1, 0};
    launch(vecs[2]);
    for (int e = 1; e <= 3; e++) begin
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
        @(posedge clk);
        #1 hit = (int'(epoch_cnt) == e);
      end
      chk($sformatf("traj_seen_e%0d", e), int'(hit), 1);
      chk($sformatf("traj_w1_e%0d", e), int'(w1_out), w_exp[e-1]);
      chk($sformatf("traj_w2_e%0d", e), int'(w2_out), w_exp[e-1]);
    end
    hit = 1'b0;
    for (int c = 0; c < 1000 && !hit; c++) begin
      @(posedge clk);
      #1 hit = done;
    end
    chk("traj_done", int'(hit), 1);
    // reset in the middle of an APPLY window of epoch 2, with start held in the reset cycle
    launch(vecs[1]);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk);
      #1 hit = (epoch_cnt == 4'd1) && v_in1;
    end
    chk("mid_apply_reached", int'(hit), 1);
    reset_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    reset_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_idle_busy", int'(busy), 0);
    chk("midrst_idle_nrst", int'(neuron_rst_n), 1);
    run(vecs[0], 1'b0, "fresh");
    run(vecs[0], 1'b1, "xstart_short");
    run(vecs[1], 1'b1, "xstart_long");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
